// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: FSM states, PC select values
// and halt causes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_e;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_TGT = 1'b1;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'b00,
        HALT_ILLEGAL = 2'b01,
        HALT_IMEM_TO = 2'b10,
        HALT_DMEM_TO = 2'b11
    } halt_cause_e;

endpackage

// File: rtl/multicycle_ctrl_watchdog.sv
// Memory-wait watchdog: counts enabled cycles since the last clear and flags the cycle
// in which the MEM_TIMEOUT-th unacknowledged wait occurs. MEM_TIMEOUT=0 never expires.
module ctrl_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q holds the waits already seen, so the current cycle is wait number cnt_q+1.
    assign expire_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer gating decoder controls into per-cycle
// strobes. Optional performance counters are built when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        dec_reg_write_en,
    input  logic        dec_mem_read_en,
    input  logic        dec_mem_write_en,
    input  logic        dec_branch_en,
    input  logic        dec_jump_en,
    input  logic        dec_illegal,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        instr_retired,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_e      state_q, state_d;
    halt_cause_e cause_q, cause_d;
    logic        wd_en, wd_clr, wd_expire;

    // Waiting means a request is outstanding and no ack arrived this cycle.
    assign wd_en  = ((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack);
    assign wd_clr = (state_d != state_q);

    ctrl_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_sel        = PC_SEL_SEQ;
        rf_we         = 1'b0;
        instr_retired = 1'b0;
        unique case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (wd_expire) begin
                    state_d = HALT;
                    cause_d = HALT_IMEM_TO;
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    state_d = HALT;
                    cause_d = HALT_ILLEGAL;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (dec_mem_read_en || dec_mem_write_en) begin
                    state_d = MEM;
                end else if (dec_branch_en) begin
                    pc_we         = 1'b1;
                    pc_sel        = branch_taken ? PC_SEL_TGT : PC_SEL_SEQ;
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                end else if (dec_reg_write_en) begin
                    state_d = WB;
                end else begin
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write_en;
                if (dmem_ack) begin
                    if (dec_mem_write_en) begin
                        pc_we         = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wd_expire) begin
                    state_d = HALT;
                    cause_d = HALT_DMEM_TO;
                end
            end
            WB: begin
                rf_we         = 1'b1;
                pc_we         = 1'b1;
                pc_sel        = dec_jump_en ? PC_SEL_TGT : PC_SEL_SEQ;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cause_q <= HALT_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign halted     = (state_q == HALT);
    assign halt_cause = cause_q;
    assign state      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != HALT)
                cycle_q <= cycle_q + 32'd1;
            if (instr_retired)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It consumes the instruction decoder's control outputs and gates them into per-cycle enables: IR latch, PC update, register-file write and data-memory request. It also owns the req/ack handshakes to instruction and data memory, with a watchdog on each.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory req may wait for ack; 0 disables watchdog
TO_W, 5, watchdog counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  instruction fetch request, held until imem_ack
imem_ack  in  1  one-cycle pulse: instruction data valid this cycle
dmem_req  out  1  data memory request, held until dmem_ack
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
dmem_ack  in  1  one-cycle pulse: load data valid / store accepted
dec_reg_write_en  in  1  from decoder
dec_mem_read_en  in  1  from decoder
dec_mem_write_en  in  1  from decoder
dec_branch_en  in  1  from decoder
dec_jump_en  in  1  from decoder
dec_illegal  in  1  opcode not in decoder's supported set
branch_taken  in  1  branch comparator result, valid in EXECUTE
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
pc_sel  out  1  0 = PC+4, 1 = branch/jump target
rf_we  out  1  register file write strobe
instr_retired  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky; core stopped
halt_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
state  out  3  current FSM state, for debug
cycle_cnt  out  32  performance counter (see Optional Feature)
instret_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is synchronous and active-low.
- On rst_n=0 at an edge:
  - state=FETCH; halted=0; halt_cause=00; watchdog=0.
  - All strobes 0: ir_we, pc_we, rf_we, instr_retired, dmem_req.
  - imem_req is a Moore output, so it is 1 in FETCH immediately after reset.
  - A reset mid-transaction drops dmem_req on the next cycle. A late ack is ignored unless it arrives while in FETCH.
- Strobes are Moore/Mealy on the current state as listed below; no registered delay.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH: imem_req=1.
  - On imem_ack: ir_we=1 pulse, go to DECODE.
  - Watchdog counts each cycle without ack. When count reaches MEM_TIMEOUT: go to HALT, halt_cause=10.
- DECODE (1 cycle): dec_illegal=1 -> HALT, cause 01. Else -> EXECUTE.
- EXECUTE (1 cycle), first matching rule wins:
  - mem_read|mem_write -> MEM.
  - branch_en -> pc_we=1, pc_sel=branch_taken, instr_retired=1, -> FETCH.
  - reg_write_en -> WB.
  - otherwise -> pc_we=1, pc_sel=0, retire, -> FETCH.
- MEM: dmem_req=1, dmem_we=dec_mem_write_en (store wins if both set).
  - On dmem_ack: a load goes to WB. A store does pc_we=1, pc_sel=0, retire, -> FETCH.
  - Watchdog as in FETCH; cause 11.
- WB (1 cycle): rf_we=1, pc_we=1, pc_sel=dec_jump_en, instr_retired=1, -> FETCH.
- HALT: absorbing until reset. All strobes and reqs 0; acks ignored.
- Watchdog: cleared on state entry and on ack.
- dec_* inputs must be stable from DECODE through WB; the IR holds the instruction for that whole span. The controller does not re-register them.
- Ack pulse while the corresponding req=0: ignored.
- Latency with zero-wait ack (ack in the first FETCH/MEM cycle):
  - branch: 3 cycles
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles
  - store: 4 cycles
  - load: 5 cycles

Optional Feature:
Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - cycle_cnt increments every cycle when not halted.
  - instret_cnt increments on instr_retired.
  - Both 32-bit, wrap 0xFFFFFFFF->0, zeroed on reset.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package ctrl_pkg:
  - state encodings FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WB=4 HALT=5
  - PC_SEL_SEQ=0, PC_SEL_TGT=1
  - HALT_NONE/ILLEGAL/IMEM_TO/DMEM_TO
- Sub-module ctrl_watchdog: TO_W counter with clear and expire output, shared by FETCH and MEM.

Test Plan:
- ADD (reg_write=1), imem_ack in first FETCH cycle -> states F,D,E,W,F; rf_we and pc_we (pc_sel=0) both high exactly in cycle 4; instr_retired once.
- Load, imem_ack delayed 3 cycles, dmem_ack delayed 2 -> dmem_req held 3 cycles with dmem_we=0; rf_we 1 cycle after ack; total 10 cycles.
- BEQ, branch_taken=1 then a second BEQ with branch_taken=0 -> pc_we in EXECUTE with pc_sel=1 then 0; rf_we never asserts.
- JAL (reg_write=1, jump=1) -> WB asserts rf_we=1, pc_sel=1.
- MEM_TIMEOUT=16, store with no dmem_ack -> HALT after 16 MEM cycles, halt_cause=11, dmem_req low; later ack ignored. dec_illegal=1 -> HALT, cause 01.
- rst_n=0 for 1 cycle mid-MEM -> next cycle state=FETCH, dmem_req=0, imem_req=1. With PERF_EN, cycle_cnt=0 and instret_cnt=0 after reset.
